// File: rtl/layer_compositor.sv
// Purpose: composites NUM_RECTS rectangle sprites and NUM_DIGITS 3x5 score digits over a background colour (optional dither: define GAMEOVER_DITHER_EN).
// Latency: inputs sampled at edge t, pixelOut/pixelValid for that pixel valid after edge t+3 (input register + S1 + S2 + S3).
// Backpressure: none; streaming at one pixel per pixelClock, the downstream timing generator must accept every cycle.
module layer_compositor #(
    parameter int                 COORD_W     = 16,
    parameter int                 COLOR_W     = 3,
    parameter int                 NUM_RECTS   = 4,
    parameter int                 NUM_DIGITS  = 2,
    parameter int                 DIGIT_SCALE = 12,
    parameter int                 DIGIT_X0    = 200,
    parameter int                 DIGIT_PITCH = 364,
    parameter int                 DIGIT_Y0    = 30,
    parameter logic [COLOR_W-1:0] DIGIT_COLOR = 3'b110,
    parameter logic [COLOR_W-1:0] DIM_COLOR   = 3'b111,
    localparam int                ADDR_W      = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
    input  logic                    pixelClock,
    input  logic                    resetN,
    input  logic                    frameStart,
    input  logic                    visibleArea,
    input  logic [COORD_W-1:0]      screenX,
    input  logic [COORD_W-1:0]      screenY,
    input  logic                    objWrEn,
    input  logic [ADDR_W-1:0]       objWrAddr,
    input  logic [COORD_W-1:0]      objWrX,
    input  logic [COORD_W-1:0]      objWrY,
    input  logic [COORD_W-1:0]      objWrW,
    input  logic [COORD_W-1:0]      objWrH,
    input  logic [COLOR_W-1:0]      objWrColor,
    input  logic                    objWrVisible,
    input  logic [4*NUM_DIGITS-1:0] digitValue,
    input  logic                    gameOver,
    input  logic [COLOR_W-1:0]      backgroundColor,
    output logic [COLOR_W-1:0]      pixelOut,
    output logic                    pixelValid
);

`ifdef GAMEOVER_DITHER_EN
    localparam bit DITHER_EN = 1'b1;
`else
    localparam bit DITHER_EN = 1'b0;
`endif

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
        logic [COLOR_W-1:0] color;
        logic               visible;
    } objEntry_t;

    // One extra bit so origin + size never wraps in the hit compare.
    typedef logic [COORD_W:0] coordExt_t;

    // 3x5 glyph row lookup, MSB = leftmost column; values above 9 are blank.
    function automatic logic [2:0] glyphRow(input logic [3:0] value, input logic [2:0] row);
        logic [14:0] glyph;
        case (value)
            4'd0:    glyph = {3'b111, 3'b101, 3'b101, 3'b101, 3'b111};
            4'd1:    glyph = {3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
            4'd2:    glyph = {3'b111, 3'b001, 3'b111, 3'b100, 3'b111};
            4'd3:    glyph = {3'b111, 3'b001, 3'b111, 3'b001, 3'b111};
            4'd4:    glyph = {3'b101, 3'b101, 3'b111, 3'b001, 3'b001};
            4'd5:    glyph = {3'b111, 3'b100, 3'b111, 3'b001, 3'b111};
            4'd6:    glyph = {3'b111, 3'b100, 3'b111, 3'b101, 3'b111};
            4'd7:    glyph = {3'b111, 3'b001, 3'b001, 3'b001, 3'b001};
            4'd8:    glyph = {3'b111, 3'b101, 3'b111, 3'b101, 3'b111};
            4'd9:    glyph = {3'b111, 3'b101, 3'b111, 3'b001, 3'b001};
            default: glyph = '0;
        endcase
        glyphRow = glyph[(4 - int'(row)) * 3 +: 3];
    endfunction

    objEntry_t shadowTable [NUM_RECTS];
    objEntry_t activeTable [NUM_RECTS];
    objEntry_t wrEntry;
    logic      wrAccept;

    assign wrEntry  = '{x: objWrX, y: objWrY, w: objWrW, h: objWrH,
                        color: objWrColor, visible: objWrVisible};
    assign wrAccept = objWrEn && (int'(objWrAddr) < NUM_RECTS);

    // Shadow table takes writes any time; frameStart copies it to the active table, with same-cycle write bypass.
    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                shadowTable[i] <= '0;
                activeTable[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                if (wrAccept && int'(objWrAddr) == i) begin
                    shadowTable[i] <= wrEntry;
                end
                if (frameStart) begin
                    activeTable[i] <= (wrAccept && int'(objWrAddr) == i) ? wrEntry : shadowTable[i];
                end
            end
        end
    end

    logic                    inVisible;
    logic [COORD_W-1:0]      inX;
    logic [COORD_W-1:0]      inY;
    logic [4*NUM_DIGITS-1:0] inDigits;
    logic                    inGameOver;
    logic [COLOR_W-1:0]      inBg;

    // Input register: captures the pixel and its per-pixel side information together.
    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            inVisible  <= 1'b0;
            inX        <= '0;
            inY        <= '0;
            inDigits   <= '0;
            inGameOver <= 1'b0;
            inBg       <= '0;
        end else begin
            inVisible  <= visibleArea;
            inX        <= screenX;
            inY        <= screenY;
            inDigits   <= digitValue;
            inGameOver <= gameOver;
            inBg       <= backgroundColor;
        end
    end

    coordExt_t            xExt;
    coordExt_t            yExt;
    logic [NUM_RECTS-1:0] rectHitC;
    logic                 digitHitC;
    logic [COLOR_W-1:0]   bgC;
    logic                 colFound;
    logic                 rowFound;
    logic [1:0]           cellX;
    logic [2:0]           cellY;
    logic [3:0]           digitVal;
    logic [2:0]           glyphBits;
    coordExt_t            cellLo;

    assign xExt = coordExt_t'(inX);
    assign yExt = coordExt_t'(inY);

    // S1 rectangle hit test against the active table; zero width or height can never satisfy both bounds.
    always_comb begin
        rectHitC = '0;
        for (int i = 0; i < NUM_RECTS; i++) begin
            rectHitC[i] = activeTable[i].visible
                && xExt >= coordExt_t'(activeTable[i].x)
                && xExt <  coordExt_t'(activeTable[i].x) + coordExt_t'(activeTable[i].w)
                && yExt >= coordExt_t'(activeTable[i].y)
                && yExt <  coordExt_t'(activeTable[i].y) + coordExt_t'(activeTable[i].h);
        end
    end

    // S1 digit hit: locate the cell (last pixel of each cell pitch is a gap), then look up the glyph bit.
    always_comb begin
        digitHitC = 1'b0;
        colFound  = 1'b0;
        rowFound  = 1'b0;
        cellX     = '0;
        cellY     = '0;
        digitVal  = '0;
        glyphBits = '0;
        cellLo    = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            colFound = 1'b0;
            rowFound = 1'b0;
            cellX    = '0;
            cellY    = '0;
            digitVal = inDigits[4*d +: 4];
            for (int c = 0; c < 3; c++) begin
                cellLo = coordExt_t'(DIGIT_X0 + d * DIGIT_PITCH + c * DIGIT_SCALE);
                if (xExt >= cellLo && xExt < cellLo + coordExt_t'(DIGIT_SCALE - 1)) begin
                    colFound = 1'b1;
                    cellX    = 2'(c);
                end
            end
            for (int r = 0; r < 5; r++) begin
                cellLo = coordExt_t'(DIGIT_Y0 + r * DIGIT_SCALE);
                if (yExt >= cellLo && yExt < cellLo + coordExt_t'(DIGIT_SCALE - 1)) begin
                    rowFound = 1'b1;
                    cellY    = 3'(r);
                end
            end
            glyphBits = glyphRow(digitVal, cellY);
            if (colFound && rowFound && digitVal <= 4'd9 && glyphBits[2'd2 - cellX]) begin
                digitHitC = 1'b1;
            end
        end
    end

    // S1 background: checkerboard dim during game over when dithering is built in, plain colour otherwise.
    always_comb begin
        bgC = inBg;
        if (DITHER_EN && inGameOver) begin
            bgC = (inX[0] ^ inY[0]) ? DIM_COLOR : '0;
        end
    end

    logic [NUM_RECTS-1:0] s1RectHit;
    logic [COLOR_W-1:0]   s1RectColor [NUM_RECTS];
    logic                 s1DigitHit;
    logic                 s1Visible;
    logic [COLOR_W-1:0]   s1Bg;

    // S1 register: rect colours are captured with the hits so a commit cannot split a pixel's view of the table.
    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            s1RectHit  <= '0;
            s1DigitHit <= 1'b0;
            s1Visible  <= 1'b0;
            s1Bg       <= '0;
            for (int i = 0; i < NUM_RECTS; i++) begin
                s1RectColor[i] <= '0;
            end
        end else begin
            s1RectHit  <= rectHitC;
            s1DigitHit <= digitHitC;
            s1Visible  <= inVisible;
            s1Bg       <= bgC;
            for (int i = 0; i < NUM_RECTS; i++) begin
                s1RectColor[i] <= activeTable[i].color;
            end
        end
    end

    logic               winHitC;
    logic [COLOR_W-1:0] winColorC;

    // S2 priority mux: digits beat every rect; scanning from the top index down leaves the lowest index winning.
    always_comb begin
        winHitC   = 1'b0;
        winColorC = '0;
        for (int i = NUM_RECTS - 1; i >= 0; i--) begin
            if (s1RectHit[i]) begin
                winHitC   = 1'b1;
                winColorC = s1RectColor[i];
            end
        end
        if (s1DigitHit) begin
            winHitC   = 1'b1;
            winColorC = DIGIT_COLOR;
        end
    end

    logic               s2Hit;
    logic [COLOR_W-1:0] s2Color;
    logic               s2Visible;
    logic [COLOR_W-1:0] s2Bg;

    // S2 register: winning layer colour (black included, it is opaque) travels with its hit flag.
    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            s2Hit     <= 1'b0;
            s2Color   <= '0;
            s2Visible <= 1'b0;
            s2Bg      <= '0;
        end else begin
            s2Hit     <= winHitC;
            s2Color   <= winColorC;
            s2Visible <= s1Visible;
            s2Bg      <= s1Bg;
        end
    end

    // S3 output register: background where nothing hits, blanked outside the visible area.
    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            pixelOut   <= '0;
            pixelValid <= 1'b0;
        end else begin
            pixelOut   <= s2Visible ? (s2Hit ? s2Color : s2Bg) : '0;
            pixelValid <= s2Visible;
        end
    end

endmodule
